// File: rtl/waddr_sel_pipe_if.sv
// Decode-to-writeback bus for the write-address selector: decode fields in, writeback and hazard status out.
// master = decode/stall side, slave = waddr_sel_pipe.
interface waddr_sel_pipe_if #(
  parameter int AW = 5
);
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [1:0]    sel;
  logic          we_in;
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic          hazard;
  logic [AW-1:0] wb_waddr;
  logic          wb_we;
  logic          wb_valid;
  logic          sel_err;
  logic [31:0]   hazard_cnt;

  modport master (
    output rt, rd, sel, we_in, in_valid, stall, flush, rs_q, rt_q,
    input  hazard, wb_waddr, wb_we, wb_valid, sel_err, hazard_cnt
  );

  modport slave (
    input  rt, rd, sel, we_in, in_valid, stall, flush, rs_q, rt_q,
    output hazard, wb_waddr, wb_we, wb_valid, sel_err, hazard_cnt
  );
endinterface

// File: rtl/waddr_sel_pipe.sv
// Destination-register select + DEPTH-stage writeback pipe with RAW hazard detect; latency DEPTH cycles.
// Backpressure: stall freezes every stage (flush overrides it); HAZARD_CNT_EN adds a saturating hazard counter.
module waddr_sel_pipe #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  waddr_sel_pipe_if.slave bus
);
  typedef struct packed {
    logic          vld;
    logic          we;
    logic [AW-1:0] addr;
  } stage_t;

  stage_t stg [DEPTH];
  stage_t cap;
  logic   sel_ok;
  logic   haz;
  logic   sel_err_q;

  always_comb begin
    cap    = '0;
    sel_ok = 1'b1;
    case (bus.sel)
      2'b00:   cap.addr = bus.rt;
      2'b01:   cap.addr = bus.rd;
      2'b10:   cap.addr = AW'(LINK_REG);
      default: sel_ok   = 1'b0;
    endcase
    cap.vld = bus.in_valid;
    // Writes to register 0 are discarded here so they can never raise a hazard downstream.
    cap.we  = bus.we_in & bus.in_valid & sel_ok & (cap.addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (bus.flush || !bus.stall) begin
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
      stg[0] <= bus.flush ? '0 : cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (bus.in_valid && (bus.sel == 2'b11) && !bus.stall) begin
      sel_err_q <= 1'b1;
    end
  end

  // The last stage is included: the regfile is not write-through.
  always_comb begin
    haz = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stg[k].vld && stg[k].we &&
          (((bus.rs_q != '0) && (stg[k].addr == bus.rs_q)) ||
           ((bus.rt_q != '0) && (stg[k].addr == bus.rt_q)))) begin
        haz = 1'b1;
      end
    end
  end

  assign bus.hazard   = haz;
  assign bus.wb_waddr = stg[DEPTH-1].addr;
  assign bus.wb_we    = stg[DEPTH-1].we;
  assign bus.wb_valid = stg[DEPTH-1].vld;
  assign bus.sel_err  = sel_err_q;

`ifdef HAZARD_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (haz && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.hazard_cnt = cnt_q;
`else
  assign bus.hazard_cnt = '0;
`endif
endmodule

// File: tb/tb_waddr_sel_pipe.sv
// Directed bench for waddr_sel_pipe (AW=5, DEPTH=3, LINK_REG=31); checks land 1 time unit after each rising edge.
module tb_waddr_sel_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_cnt;

  waddr_sel_pipe_if #(.AW(5)) bus ();

  waddr_sel_pipe #(.AW(5), .DEPTH(3), .LINK_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    bus.in_valid = v;
    bus.we_in    = we;
    bus.sel      = s;
    bus.rt       = t;
    bus.rd       = d;
  endtask

  initial begin
`ifdef HAZARD_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.rs_q  = 5'd0;
    bus.rt_q  = 5'd0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_wb_waddr", 32'(bus.wb_waddr), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_hazard", 32'(bus.hazard), 32'd0);
    check("rst_sel_err", 32'(bus.sel_err), 32'd0);
    check("rst_hazard_cnt", bus.hazard_cnt, 32'd0);

    // Select paths: Rt, Rd, link on consecutive captures
    drive(1'b1, 1'b1, 2'b00, 5'd5, 5'd9); tick();
    drive(1'b1, 1'b1, 2'b01, 5'd5, 5'd9); tick();
    drive(1'b1, 1'b1, 2'b10, 5'd5, 5'd9); tick();
    check("sel_rt_waddr", 32'(bus.wb_waddr), 32'd5);
    check("sel_rt_we", 32'(bus.wb_we), 32'd1);
    check("sel_rt_valid", 32'(bus.wb_valid), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0); tick();
    check("sel_rd_waddr", 32'(bus.wb_waddr), 32'd9);
    check("sel_rd_we", 32'(bus.wb_we), 32'd1);
    tick();
    check("sel_link_waddr", 32'(bus.wb_waddr), 32'd31);
    check("sel_link_we", 32'(bus.wb_we), 32'd1);
    tick();
    check("bubble_valid", 32'(bus.wb_valid), 32'd0);

    // Illegal select, then a write to register 0
    drive(1'b1, 1'b1, 2'b11, 5'd5, 5'd9); tick();
    check("sel_err_set", 32'(bus.sel_err), 32'd1);
    drive(1'b1, 1'b1, 2'b00, 5'd0, 5'd9); tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0); tick();
    check("illegal_valid", 32'(bus.wb_valid), 32'd1);
    check("illegal_we", 32'(bus.wb_we), 32'd0);
    check("illegal_waddr", 32'(bus.wb_waddr), 32'd0);
    tick();
    check("r0_valid", 32'(bus.wb_valid), 32'd1);
    check("r0_we", 32'(bus.wb_we), 32'd0);
    check("sel_err_sticky", 32'(bus.sel_err), 32'd1);

    // Stall for two cycles after capturing r4
    drive(1'b1, 1'b1, 2'b00, 5'd4, 5'd0); tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    bus.stall = 1'b1; tick(); tick();
    bus.stall = 1'b0; tick();
    check("stall_early_valid", 32'(bus.wb_valid), 32'd0);
    tick();
    check("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("stall_wb_waddr", 32'(bus.wb_waddr), 32'd4);
    check("stall_wb_we", 32'(bus.wb_we), 32'd1);

    // Flush squashes the capture of r6
    drive(1'b1, 1'b1, 2'b00, 5'd6, 5'd0);
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    bus.rs_q = 5'd6;
    check("flush_hazard_s0", 32'(bus.hazard), 32'd0);
    tick();
    check("flush_hazard_s1", 32'(bus.hazard), 32'd0);
    tick();
    check("flush_hazard_s2", 32'(bus.hazard), 32'd0);
    check("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
    bus.rs_q = 5'd0;

    // Reset with three writes in flight
    drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd0); tick();
    drive(1'b1, 1'b1, 2'b00, 5'd2, 5'd0); tick();
    drive(1'b1, 1'b1, 2'b00, 5'd3, 5'd0); tick();
    check("inflight_wb_waddr", 32'(bus.wb_waddr), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    rst = 1'b1; tick();
    rst = 1'b0;
    bus.rs_q = 5'd2;
    bus.rt_q = 5'd3;
    #1;
    check("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("midrst_wb_we", 32'(bus.wb_we), 32'd0);
    check("midrst_hazard", 32'(bus.hazard), 32'd0);
    check("midrst_sel_err", 32'(bus.sel_err), 32'd0);
    check("midrst_hazard_cnt", bus.hazard_cnt, 32'd0);
    bus.rs_q = 5'd0;
    bus.rt_q = 5'd0;

    // Hazard on rs_q against r7 for its three stages
    drive(1'b1, 1'b1, 2'b00, 5'd7, 5'd0); tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    bus.rs_q = 5'd7;
    #1;
    check("haz_s0", 32'(bus.hazard), 32'd1);
    tick();
    check("haz_s1", 32'(bus.hazard), 32'd1);
    tick();
    check("haz_s2", 32'(bus.hazard), 32'd1);
    tick();
    check("haz_clear", 32'(bus.hazard), 32'd0);
    check("haz_cnt", bus.hazard_cnt, exp_cnt);
    bus.rs_q = 5'd0;

    // Register 0 never matches
    drive(1'b1, 1'b1, 2'b00, 5'd0, 5'd0); tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    check("haz_r0", 32'(bus.hazard), 32'd0);

    // rt_q path against an Rd-selected write
    drive(1'b1, 1'b1, 2'b01, 5'd0, 5'd12); tick();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    bus.rt_q = 5'd12;
    #1;
    check("haz_rt_q", 32'(bus.hazard), 32'd1);
    bus.rt_q = 5'd0;
    tick();
    check("haz_cnt_hold", bus.hazard_cnt, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
